// File: rtl/ram_word_fetch.sv
// Serves 16-bit word requests from a 32-bit Wishbone-style read bus through a one-line cache.
// Bus errors and timeouts return a zero word and raise a sticky fetch_err.
module ram_word_fetch #(
    parameter int RAM_WID      = 32,
    parameter int RAM_WORD_WID = 16,
    parameter int BUS_WID      = 32,
    parameter int TIMEOUT_WID  = 8,
    parameter int TIMEOUT      = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ram_read,
    input  logic [RAM_WID-1:0]      ram_dma_addr,
    output logic [RAM_WORD_WID-1:0] ram_word,
    output logic                    ram_valid,
    input  logic                    invalidate,
    input  logic                    err_clr,
    output logic                    fetch_err,
    output logic [RAM_WID-1:0]      bus_adr,
    output logic                    bus_cyc,
    output logic                    bus_stb,
    input  logic                    bus_ack,
    input  logic                    bus_err,
    input  logic [BUS_WID-1:0]      bus_dat_r
);

    // state   | meaning
    // IDLE    | waiting for a new request (ram_read high, ram_valid low)
    // BUS     | bus read outstanding, timeout counter running
    // HOLD    | ram_word/ram_valid presented until ram_read falls

    localparam int TAG_WID = RAM_WID - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [TAG_WID-1:0]      req_tag_q, req_tag_d;
    logic                    req_sel_q, req_sel_d;
    logic [TAG_WID-1:0]      cache_tag_q, cache_tag_d;
    logic [BUS_WID-1:0]      cache_dat_q, cache_dat_d;
    logic                    cache_vld_q, cache_vld_d;
    logic [TIMEOUT_WID-1:0]  cnt_q, cnt_d;
    logic                    dropped_q, dropped_d;
    logic                    skip_fill_q, skip_fill_d;
    logic [RAM_WORD_WID-1:0] ram_word_q, ram_word_d;
    logic                    ram_valid_q, ram_valid_d;
    logic                    fetch_err_q, fetch_err_d;
    logic [RAM_WID-1:0]      bus_adr_q, bus_adr_d;
    logic                    bus_cyc_q, bus_cyc_d;

    logic [TAG_WID-1:0] addr_tag;
    logic               addr_sel;
    logic               hit;
    logic               bus_fail;
    logic               drop_now;
    logic               set_err;
    logic               unused_addr_lsb;

    function automatic logic [RAM_WORD_WID-1:0] pick_half(input logic [BUS_WID-1:0] dat,
                                                          input logic sel);
        return sel ? dat[BUS_WID-1:RAM_WORD_WID] : dat[RAM_WORD_WID-1:0];
    endfunction

    assign addr_tag        = ram_dma_addr[RAM_WID-1:2];
    assign addr_sel        = ram_dma_addr[1];
    assign unused_addr_lsb = ram_dma_addr[0];

    // An invalidate on the same edge as the lookup must force a miss.
    assign hit      = cache_vld_q && !invalidate && (cache_tag_q == addr_tag);
    // ack and err together count as an error.
    assign bus_fail = bus_err || ((cnt_q == TIMEOUT_WID'(TIMEOUT - 1)) && !bus_ack);
    assign drop_now = dropped_q || !ram_read;

    always_comb begin
        state_d     = state_q;
        req_tag_d   = req_tag_q;
        req_sel_d   = req_sel_q;
        cache_tag_d = cache_tag_q;
        cache_dat_d = cache_dat_q;
        cache_vld_d = cache_vld_q;
        cnt_d       = cnt_q;
        dropped_d   = dropped_q;
        skip_fill_d = skip_fill_q;
        ram_word_d  = ram_word_q;
        ram_valid_d = ram_valid_q;
        fetch_err_d = fetch_err_q;
        bus_adr_d   = bus_adr_q;
        bus_cyc_d   = bus_cyc_q;
        set_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ram_read && !ram_valid_q) begin
                    req_tag_d = addr_tag;
                    req_sel_d = addr_sel;
                    if (hit) begin
                        ram_word_d  = pick_half(cache_dat_q, addr_sel);
                        ram_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        bus_adr_d   = {addr_tag, 2'b00};
                        bus_cyc_d   = 1'b1;
                        cnt_d       = '0;
                        dropped_d   = 1'b0;
                        skip_fill_d = 1'b0;
                        state_d     = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                cnt_d = cnt_q + TIMEOUT_WID'(1);
                if (!ram_read) begin
                    dropped_d = 1'b1;
                end
                if (invalidate) begin
                    skip_fill_d = 1'b1;
                end
                if (bus_fail) begin
                    bus_cyc_d = 1'b0;
                    set_err   = 1'b1;
                    if (drop_now) begin
                        state_d = ST_IDLE;
                    end else begin
                        ram_word_d  = '0;
                        ram_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end else if (bus_ack) begin
                    bus_cyc_d = 1'b0;
                    // A line invalidated while in flight is delivered but not kept.
                    if (!(skip_fill_q || invalidate)) begin
                        cache_tag_d = req_tag_q;
                        cache_dat_d = bus_dat_r;
                        cache_vld_d = 1'b1;
                    end
                    if (drop_now) begin
                        state_d = ST_IDLE;
                    end else begin
                        ram_word_d  = pick_half(bus_dat_r, req_sel_q);
                        ram_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (!ram_read) begin
                    ram_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                bus_cyc_d   = 1'b0;
                ram_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        if (invalidate) begin
            cache_vld_d = 1'b0;
        end
        if (err_clr) begin
            fetch_err_d = 1'b0;
        end
        if (set_err) begin
            fetch_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_tag_q   <= '0;
            req_sel_q   <= 1'b0;
            cache_tag_q <= '0;
            cache_dat_q <= '0;
            cache_vld_q <= 1'b0;
            cnt_q       <= '0;
            dropped_q   <= 1'b0;
            skip_fill_q <= 1'b0;
            ram_word_q  <= '0;
            ram_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
            bus_adr_q   <= '0;
            bus_cyc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_tag_q   <= req_tag_d;
            req_sel_q   <= req_sel_d;
            cache_tag_q <= cache_tag_d;
            cache_dat_q <= cache_dat_d;
            cache_vld_q <= cache_vld_d;
            cnt_q       <= cnt_d;
            dropped_q   <= dropped_d;
            skip_fill_q <= skip_fill_d;
            ram_word_q  <= ram_word_d;
            ram_valid_q <= ram_valid_d;
            fetch_err_q <= fetch_err_d;
            bus_adr_q   <= bus_adr_d;
            bus_cyc_q   <= bus_cyc_d;
        end
    end

    assign ram_word  = ram_word_q;
    assign ram_valid = ram_valid_q;
    assign fetch_err = fetch_err_q;
    assign bus_adr   = bus_adr_q;
    assign bus_cyc   = bus_cyc_q;
    assign bus_stb   = bus_cyc_q;

endmodule

// File: tb/tb_ram_word_fetch.sv
// Bench for ram_word_fetch: a transaction-level cache model sets the expected outputs,
// a negedge process compares them every cycle, and literal checks pin key values.
module tb_ram_word_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_read = 1'b0;
    logic [31:0] ram_dma_addr = '0;
    logic [15:0] ram_word;
    logic        ram_valid;
    logic        invalidate = 1'b0;
    logic        err_clr = 1'b0;
    logic        fetch_err;
    logic [31:0] bus_adr;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_dat_r = '0;

    ram_word_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .ram_read    (ram_read),
        .ram_dma_addr(ram_dma_addr),
        .ram_word    (ram_word),
        .ram_valid   (ram_valid),
        .invalidate  (invalidate),
        .err_clr     (err_clr),
        .fetch_err   (fetch_err),
        .bus_adr     (bus_adr),
        .bus_cyc     (bus_cyc),
        .bus_stb     (bus_stb),
        .bus_ack     (bus_ack),
        .bus_err     (bus_err),
        .bus_dat_r   (bus_dat_r)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected outputs
    logic        check_en = 1'b0;
    logic        exp_cyc = 1'b0;
    logic [31:0] exp_adr = '0;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_word = '0;
    logic        exp_err = 1'b0;

    // cache model and pending request
    logic        m_valid = 1'b0;
    logic [29:0] m_tag = '0;
    logic [31:0] m_data = '0;
    logic [29:0] p_tag = '0;
    logic        p_sel = 1'b0;
    logic        p_inval = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("bus_cyc", {31'd0, bus_cyc}, {31'd0, exp_cyc});
            chk("bus_stb", {31'd0, bus_stb}, {31'd0, exp_cyc});
            if (exp_cyc) chk("bus_adr", bus_adr, exp_adr);
            chk("ram_valid", {31'd0, ram_valid}, {31'd0, exp_valid});
            if (exp_valid) chk("ram_word", {16'd0, ram_word}, {16'd0, exp_word});
            chk("fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_read(input logic [31:0] a);
        ram_dma_addr = a;
        ram_read     = 1'b1;
        p_tag        = a[31:2];
        p_sel        = a[1];
        p_inval      = 1'b0;
        tick;
        if (m_valid && m_tag == p_tag) begin
            exp_valid = 1'b1;
            exp_word  = p_sel ? m_data[31:16] : m_data[15:0];
        end else begin
            exp_cyc = 1'b1;
            exp_adr = {p_tag, 2'b00};
        end
    endtask

    task automatic bus_finish(input int waits, input logic [31:0] dat, input logic ack,
                              input logic err, input logic clr);
        repeat (waits) tick;
        bus_dat_r = dat;
        bus_ack   = ack;
        bus_err   = err;
        err_clr   = clr;
        tick;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        err_clr   = 1'b0;
        bus_dat_r = '0;
        exp_cyc   = 1'b0;
        if (clr) exp_err = 1'b0;
        if (err) begin
            exp_err = 1'b1;
            if (ram_read) begin
                exp_valid = 1'b1;
                exp_word  = 16'h0000;
            end
        end else begin
            if (!p_inval) begin
                m_valid = 1'b1;
                m_tag   = p_tag;
                m_data  = dat;
            end
            if (ram_read) begin
                exp_valid = 1'b1;
                exp_word  = p_sel ? dat[31:16] : dat[15:0];
            end
        end
    endtask

    task automatic timeout_wait;
        repeat (199) tick;
        tick;
        exp_cyc = 1'b0;
        exp_err = 1'b1;
        if (ram_read) begin
            exp_valid = 1'b1;
            exp_word  = 16'h0000;
        end
    endtask

    task automatic hold_and_end;
        tick;
        tick;
        ram_read = 1'b0;
        tick;
        exp_valid = 1'b0;
    endtask

    task automatic pulse_inval;
        invalidate = 1'b1;
        tick;
        invalidate = 1'b0;
        m_valid    = 1'b0;
        if (exp_cyc) p_inval = 1'b1;
    endtask

    task automatic pulse_clr;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset ram_valid", {31'd0, ram_valid}, 32'd0);
        chk("reset bus_cyc", {31'd0, bus_cyc}, 32'd0);
        chk("reset fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("reset ram_word", {16'd0, ram_word}, 32'd0);
        rst      = 1'b0;
        check_en = 1'b1;
        tick;

        // prefill the line, then an error with ack+err+err_clr together
        start_read(32'h0001_2340);
        bus_finish(1, 32'hBEEF_CAFE, 1'b1, 1'b0, 1'b0);
        hold_and_end;
        start_read(32'h0005_0000);
        bus_finish(2, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        chk("ack+err fetch_err", {31'd0, fetch_err}, 32'd1);
        chk("ack+err ram_word", {16'd0, ram_word}, 32'h0000);
        hold_and_end;

        // reset in the middle of a bus cycle
        start_read(32'h0003_0000);
        tick;
        #2;
        rst      = 1'b1;
        check_en = 1'b0;
        #1;
        chk("async rst bus_cyc", {31'd0, bus_cyc}, 32'd0);
        chk("async rst bus_stb", {31'd0, bus_stb}, 32'd0);
        chk("async rst ram_valid", {31'd0, ram_valid}, 32'd0);
        chk("async rst fetch_err", {31'd0, fetch_err}, 32'd0);
        ram_read  = 1'b0;
        exp_cyc   = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        m_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;
        tick;

        // miss after reset, then the other halfword hits
        start_read(32'h0001_2340);
        chk("t2 bus_adr", bus_adr, 32'h0001_2340);
        bus_finish(3, 32'hBEEF_CAFE, 1'b1, 1'b0, 1'b0);
        chk("t2 word lo", {16'd0, ram_word}, 32'h0000_CAFE);
        hold_and_end;
        start_read(32'h0001_2342);
        chk("t2 hit valid", {31'd0, ram_valid}, 32'd1);
        chk("t2 hit no bus", {31'd0, bus_cyc}, 32'd0);
        chk("t2 word hi", {16'd0, ram_word}, 32'h0000_BEEF);
        hold_and_end;

        // different line, then odd byte address
        start_read(32'h0001_2344);
        chk("t3 bus_adr", bus_adr, 32'h0001_2344);
        bus_finish(2, 32'h5566_7788, 1'b1, 1'b0, 1'b0);
        chk("t3 word", {16'd0, ram_word}, 32'h0000_7788);
        hold_and_end;
        start_read(32'h0001_2341);
        chk("t3 odd bus_adr", bus_adr, 32'h0001_2340);
        bus_finish(1, 32'hBEEF_CAFE, 1'b1, 1'b0, 1'b0);
        chk("t3 odd word", {16'd0, ram_word}, 32'h0000_CAFE);
        hold_and_end;

        // timeout, then err_clr; cache untouched by the failed fetch
        start_read(32'h0002_0000);
        timeout_wait;
        chk("t4 word", {16'd0, ram_word}, 32'h0000);
        chk("t4 fetch_err", {31'd0, fetch_err}, 32'd1);
        chk("t4 bus_cyc", {31'd0, bus_cyc}, 32'd0);
        hold_and_end;
        pulse_clr;
        chk("t4 err_clr", {31'd0, fetch_err}, 32'd0);
        start_read(32'h0001_2342);
        chk("t4 cache kept", {16'd0, ram_word}, 32'h0000_BEEF);
        hold_and_end;

        // invalidate between reads
        start_read(32'h0001_2340);
        hold_and_end;
        pulse_inval;
        start_read(32'h0001_2342);
        chk("t5 refetch adr", bus_adr, 32'h0001_2340);
        bus_finish(1, 32'hBEEF_CAFE, 1'b1, 1'b0, 1'b0);
        chk("t5 word", {16'd0, ram_word}, 32'h0000_BEEF);
        hold_and_end;

        // consumer drops the request mid-bus; line still cached
        pulse_inval;
        start_read(32'h0001_2340);
        tick;
        ram_read = 1'b0;
        tick;
        bus_finish(1, 32'h1111_2222, 1'b1, 1'b0, 1'b0);
        chk("t6 no valid", {31'd0, ram_valid}, 32'd0);
        tick;
        tick;
        start_read(32'h0001_2342);
        chk("t6 hit no bus", {31'd0, bus_cyc}, 32'd0);
        chk("t6 word", {16'd0, ram_word}, 32'h0000_1111);
        hold_and_end;

        // invalidate while the fetch is in flight
        start_read(32'h0004_0000);
        tick;
        pulse_inval;
        bus_finish(1, 32'hAAAA_BBBB, 1'b1, 1'b0, 1'b0);
        chk("t7 word", {16'd0, ram_word}, 32'h0000_BBBB);
        hold_and_end;
        start_read(32'h0004_0002);
        chk("t7 not cached", {31'd0, bus_cyc}, 32'd1);
        bus_finish(0, 32'hAAAA_BBBB, 1'b1, 1'b0, 1'b0);
        chk("t7 refetch word", {16'd0, ram_word}, 32'h0000_AAAA);
        hold_and_end;

        tick;
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
